star_cam_responder: RTL
=======================

# star_cam_responder

Responder side of the STAR softmax row protocol. It answers the controller's CAM match, match-vector subtraction and exponent requests from a loadable key/exp lookup table, and accumulates the per-row sum of exponents. It sits between the STAR controller and the LUT storage, replacing the behavioural memory models with synthesizable logic.

## Interface
- LUT_LEN, 64: number of LUT entries, which is also the match-vector width.
- DATA_W, 8: key and xi width.
- EXP_W, 32: exp and sum width.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- lut_we  in  1  LUT write strobe.
- lut_addr  in  log2(LUT_LEN)  LUT write index.
- lut_key  in  DATA_W  key written at lut_addr.
- lut_exp  in  EXP_W  exp value written at lut_addr.
- cam_req  in  1  match request.
- xi  in  DATA_W  value to match.
- sub_req  in  1  subtraction request.
- xmax_mv  in  LUT_LEN  one-hot max vector.
- xi_mv  in  LUT_LEN  one-hot element vector.
- exp_req  in  1  exponent/accumulate request.
- sub_mv  in  LUT_LEN  one-hot difference vector, used for accumulation and readback.
- o_match_mv  out  LUT_LEN  CAM result.
- o_diff_mv  out  LUT_LEN  subtraction result.
- o_exp  out  EXP_W  looked-up exp.
- o_sum_exp  out  EXP_W  row sum.
- o_sum_valid  out  1  o_sum_exp is final.
- o_err  out  1  sticky protocol/data error.

## Operation
- States: IDLE, MATCH, SUB, ACC, HOLD.
- IDLE → MATCH on cam_req.
- MATCH → SUB on sub_req.
- SUB → ACC on exp_req.
- ACC → HOLD on the first cycle with exp_req low.
- HOLD → MATCH on cam_req; this starts a new row.
- Any request not listed for the current state:
  - ignored, o_err set, state unchanged;
  - exceptions: cam_req and sub_req repeat in their own state.
- Simultaneous requests: priority cam_req > sub_req > exp_req. Any overlap sets o_err.
- LUT writes:
  - accepted only in IDLE or HOLD; a write in any other state is dropped and sets o_err;
  - key and exp are written to the same address in one cycle.
- Match: o_match_mv[k] = (key[k] == xi). Multiple hits set o_err; all hit bits are still driven.
- Subtraction:
  - ix = index(xmax_mv), ii = index(xi_mv);
  - o_diff_mv = one-hot at (ix − ii);
  - zero if either input is not exactly one-hot or if ii > ix; both cases set o_err.
- Accumulation:
  - on entry to ACC, the accumulator loads exp[index(sub_mv)] instead of adding;
  - each later exp_req cycle adds exp[index(sub_mv)];
  - a zero sub_mv adds 0 with no error;
  - a multi-hot sub_mv adds 0 and sets o_err.
- Sum width: EXP_W; overflow behaviour depends on the macro (see Configuration).
- Readback:
  - in HOLD, every cycle o_exp = exp[index(sub_mv)], or 0 if sub_mv is not one-hot;
  - in ACC, o_exp shows the term being added.
- o_sum_valid = 1 only in HOLD.
- o_err clears only on reset.

## Timing
- All outputs are registered. Every response has 1-cycle latency from the request cycle.
- Output values when no request is present:
  - o_match_mv = 0 the cycle after a non-cam_req cycle;
  - o_diff_mv = 0 the cycle after a non-sub_req cycle.
- o_sum_exp updates the cycle after each accepted exp_req. It holds in HOLD and clears to 0 the cycle after the HOLD→MATCH transition.
- Reset values:
  - state IDLE;
  - all outputs 0;
  - LUT keys and exps 0.
- Reset mid-row aborts the row. No partial sum survives.

## Configuration
- STAR_SUM_SAT_EN defined: accumulator saturates at 2^EXP_W−1 and sets o_err on the first saturation.
- STAR_SUM_SAT_EN undefined: accumulator wraps modulo 2^EXP_W with no error.

## Structure
- star_pkg holds:
  - LUT_LEN/DATA_W/EXP_W defaults;
  - the state enum;
  - the onehot_status typedef {none, one, multi}.
- Sub-module star_onehot_enc takes a LUT_LEN vector and outputs its index and onehot_status. It is instanced three times: for the subtraction inputs (×2) and for sub_mv.

## Test plan
- Load key[k]=k, exp[k]=k+1 for k=0..63. Then cam_req with xi=5 → o_match_mv=1<<5 next cycle, o_err=0.
- In MATCH, sub_req with xmax_mv=1<<10, xi_mv=1<<3 → o_diff_mv=1<<7. Repeat with xi_mv=1<<12 → o_diff_mv=0 and o_err=1.
- exp_req for 4 cycles with sub_mv=1<<0,1<<1,1<<2,1<<3, then drop exp_req → o_sum_exp=10 and o_sum_valid=1 in HOLD. In HOLD, sub_mv=1<<2 → o_exp=3.
- Load exp[0]=0xFFFF_FFF0, accumulate it twice:
  - macro defined → o_sum_exp=0xFFFF_FFFF and o_err=1;
  - macro undefined → o_sum_exp=0xFFFF_FFE0 and o_err=0.
- cam_req and exp_req together in MATCH → match served, o_err=1. lut_we during ACC → LUT unchanged.
- Assert reset during ACC → all outputs 0 and state IDLE. The next row's sum excludes pre-reset terms.

Source files
------------

// File: rtl/star_pkg.sv
// Shared definitions for the STAR CAM responder: default sizes, the
// responder state encoding and the one-hot classification type.
package star_pkg;

    localparam int STAR_LUT_LEN = 64;
    localparam int STAR_DATA_W  = 8;
    localparam int STAR_EXP_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MATCH,
        ST_SUB,
        ST_ACC,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        OH_NONE,
        OH_ONE,
        OH_MULTI
    } onehot_status;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_CAM,
        REQ_SUB,
        REQ_EXP
    } req_t;

endpackage

// File: rtl/star_onehot_enc.sv
// One-hot encoder: reports the bit index of a one-hot vector and whether
// the vector is empty, exactly one-hot, or has several bits set. The
// index is only meaningful when the status is OH_ONE.
module star_onehot_enc
    import star_pkg::*;
#(
    parameter int WIDTH = STAR_LUT_LEN,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output onehot_status     status
);

    logic [WIDTH-1:0] low_cleared;

    // OR together the indices of set bits and classify by clearing the lowest set bit
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        low_cleared = vec & (vec - WIDTH'(1));
        if (vec == '0) begin
            status = OH_NONE;
        end else if (low_cleared != '0) begin
            status = OH_MULTI;
        end else begin
            status = OH_ONE;
        end
    end

endmodule

// File: rtl/star_cam_responder.sv
// STAR softmax row responder: serves CAM match, match-vector subtraction
// and exponent/accumulate requests from a loadable key/exp table and keeps
// the per-row sum of exponents. All outputs are registered.
// Build option: STAR_SUM_SAT_EN makes the row sum saturate (and flag an
// error) instead of wrapping.
module star_cam_responder
    import star_pkg::*;
#(
    parameter int LUT_LEN = STAR_LUT_LEN,
    parameter int DATA_W  = STAR_DATA_W,
    parameter int EXP_W   = STAR_EXP_W,
    localparam int IDX_W  = $clog2(LUT_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lut_we,
    input  logic [IDX_W-1:0]   lut_addr,
    input  logic [DATA_W-1:0]  lut_key,
    input  logic [EXP_W-1:0]   lut_exp,
    input  logic               cam_req,
    input  logic [DATA_W-1:0]  xi,
    input  logic               sub_req,
    input  logic [LUT_LEN-1:0] xmax_mv,
    input  logic [LUT_LEN-1:0] xi_mv,
    input  logic               exp_req,
    input  logic [LUT_LEN-1:0] sub_mv,
    output logic [LUT_LEN-1:0] o_match_mv,
    output logic [LUT_LEN-1:0] o_diff_mv,
    output logic [EXP_W-1:0]   o_exp,
    output logic [EXP_W-1:0]   o_sum_exp,
    output logic               o_sum_valid,
    output logic               o_err
);

    state_t             state;
    logic [DATA_W-1:0]  key_mem [LUT_LEN];
    logic [EXP_W-1:0]   exp_mem [LUT_LEN];

    logic [IDX_W-1:0]   xmax_idx;
    logic [IDX_W-1:0]   xi_idx;
    logic [IDX_W-1:0]   sub_idx;
    onehot_status       xmax_st;
    onehot_status       xi_st;
    onehot_status       sub_st;

    logic [LUT_LEN-1:0] hits;
    logic               multi_hit;
    req_t               top_req;
    logic               overlap;
    logic               cam_ok;
    logic               sub_ok;
    logic               exp_ok;
    logic               illegal;
    logic               lut_ok;
    logic               diff_bad;
    logic [LUT_LEN-1:0] diff_val;
    logic [EXP_W-1:0]   term;
    logic               term_multi;
    logic [EXP_W-1:0]   acc_next;
    logic               sat_hit;
`ifdef STAR_SUM_SAT_EN
    logic [EXP_W:0]     wide_sum;
`endif

    star_onehot_enc #(.WIDTH(LUT_LEN)) u_enc_xmax (
        .vec    (xmax_mv),
        .idx    (xmax_idx),
        .status (xmax_st)
    );

    star_onehot_enc #(.WIDTH(LUT_LEN)) u_enc_xi (
        .vec    (xi_mv),
        .idx    (xi_idx),
        .status (xi_st)
    );

    star_onehot_enc #(.WIDTH(LUT_LEN)) u_enc_sub (
        .vec    (sub_mv),
        .idx    (sub_idx),
        .status (sub_st)
    );

    // Compare xi against every stored key in parallel and detect duplicate hits
    always_comb begin
        hits = '0;
        for (int k = 0; k < LUT_LEN; k++) begin
            hits[k] = (key_mem[k] == xi);
        end
        multi_hit = (hits & (hits - LUT_LEN'(1))) != '0;
    end

    // Pick the highest-priority request and decide whether this state may serve it
    always_comb begin
        top_req = REQ_NONE;
        if (cam_req) begin
            top_req = REQ_CAM;
        end else if (sub_req) begin
            top_req = REQ_SUB;
        end else if (exp_req) begin
            top_req = REQ_EXP;
        end
        overlap = (cam_req & sub_req) | (cam_req & exp_req) | (sub_req & exp_req);
        cam_ok  = (top_req == REQ_CAM) &&
                  (state == ST_IDLE || state == ST_MATCH || state == ST_HOLD);
        sub_ok  = (top_req == REQ_SUB) && (state == ST_MATCH || state == ST_SUB);
        exp_ok  = (top_req == REQ_EXP) && (state == ST_SUB || state == ST_ACC);
        illegal = (top_req != REQ_NONE) && !(cam_ok || sub_ok || exp_ok);
        lut_ok  = (state == ST_IDLE) || (state == ST_HOLD);
    end

    // Subtraction result, exponent term selected by sub_mv, and the next row sum
    always_comb begin
        diff_bad   = (xmax_st != OH_ONE) || (xi_st != OH_ONE) || (xi_idx > xmax_idx);
        diff_val   = diff_bad ? '0 : (LUT_LEN'(1) << (xmax_idx - xi_idx));
        term       = (sub_st == OH_ONE) ? exp_mem[sub_idx] : '0;
        term_multi = (sub_st == OH_MULTI);
`ifdef STAR_SUM_SAT_EN
        wide_sum   = {1'b0, o_sum_exp} + {1'b0, term};
        sat_hit    = wide_sum[EXP_W];
        acc_next   = sat_hit ? '1 : wide_sum[EXP_W-1:0];
`else
        sat_hit    = 1'b0;
        acc_next   = o_sum_exp + term;
`endif
    end

    // Row-protocol state machine with the LUT storage and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            o_match_mv  <= '0;
            o_diff_mv   <= '0;
            o_exp       <= '0;
            o_sum_exp   <= '0;
            o_sum_valid <= 1'b0;
            o_err       <= 1'b0;
            for (int k = 0; k < LUT_LEN; k++) begin
                key_mem[k] <= '0;
                exp_mem[k] <= '0;
            end
        end else begin
            o_match_mv <= cam_ok ? hits : '0;
            o_diff_mv  <= sub_ok ? diff_val : '0;
            o_exp      <= '0;

            if (lut_we && lut_ok) begin
                key_mem[lut_addr] <= lut_key;
                exp_mem[lut_addr] <= lut_exp;
            end

            if (overlap || illegal || (lut_we && !lut_ok) ||
                (cam_ok && multi_hit) || (sub_ok && diff_bad) ||
                (exp_ok && term_multi) ||
                (exp_ok && state == ST_ACC && sat_hit)) begin
                o_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cam_ok) begin
                        state <= ST_MATCH;
                    end
                end
                ST_MATCH: begin
                    if (sub_ok) begin
                        state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    if (exp_ok) begin
                        state     <= ST_ACC;
                        o_sum_exp <= term;
                        o_exp     <= term;
                    end
                end
                ST_ACC: begin
                    if (exp_ok) begin
                        o_sum_exp <= acc_next;
                        o_exp     <= term;
                    end else if (!exp_req) begin
                        state       <= ST_HOLD;
                        o_sum_valid <= 1'b1;
                        o_exp       <= term;
                    end
                end
                ST_HOLD: begin
                    if (cam_ok) begin
                        state       <= ST_MATCH;
                        o_sum_exp   <= '0;
                        o_sum_valid <= 1'b0;
                    end else begin
                        o_exp <= term;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
